// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size codes, FSM states, alignment check.
// Imported by lsu_lane and dmem_lsu.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } lsu_state_t;

  // Misaligned half/word or reserved size: answered with an error, no memory access.
  function automatic logic lsu_bad(input logic [1:0] size,
                                   input logic [1:0] lo);
    return (size == SZ_RSVD)
         | ((size == SZ_HALF) & lo[0])
         | ((size == SZ_WORD) & (|lo));
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Lane extract/extend for loads and lane merge for sub-word stores (little-endian).
// Ports: size, sext, lo (addr[1:0]), word (read), wdata -> ext (load), merged (store).
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [4:0]  bsh;
  logic [7:0]  b;
  logic [15:0] h;

  assign bsh = {lo, 3'b000};

  always_comb begin
    b      = word[bsh +: 8];
    h      = lo[1] ? word[31:16] : word[15:0];
    ext    = word;
    merged = wdata;
    unique case (size)
      SZ_BYTE: begin
        ext = {{24{sext & b[7]}}, b};
        merged = word;
        merged[bsh +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ext = {{16{sext & h[15]}}, h};
        merged = word;
        if (lo[1]) merged[31:16] = wdata[15:0];
        else       merged[15:0]  = wdata[15:0];
      end
      default: begin
        ext    = word;
        merged = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator to a word-wide memory with one-cycle registered read.
// Ports: req_* (request in), resp_* (one-cycle response), mem_* (memory port).
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  lsu_state_t        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       merge_q, merge_d;
  logic              err_q, err_d;

  logic              acc;
  logic              bad;
  logic              wstore;
  logic [31:0]       ext;
  logic [31:0]       merged;
  logic              unused_hi;

  // Upper address bits alias onto the same memory.
  assign unused_hi = ^req_addr[31:ADDR_W];

  assign acc    = req_valid & (state_q == ST_IDLE);
  assign bad    = lsu_bad(req_size, req_addr[1:0]);
  assign wstore = we_q & (size_q == SZ_WORD);

  lsu_lane u_lane (
    .size   (size_q),
    .sext   (sgn_q),
    .lo     (addr_q[1:0]),
    .word   (mem_rd),
    .wdata  (wdata_q),
    .ext    (ext),
    .merged (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      merge_q <= merge_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (acc) state_d = bad ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_d = wstore ? ST_DONE : ST_WAIT;
      ST_WAIT:  state_d = we_q ? ST_WRITE : ST_DONE;
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    merge_d = merge_q;
    err_d   = err_q;
    if (acc) begin
      we_d    = req_we;
      size_d  = req_size;
      sgn_d   = req_signed;
      addr_d  = req_addr[ADDR_W-1:0];
      wdata_d = req_wdata;
      rdata_d = '0;
      err_d   = bad;
    end
    if (state_q == ST_WAIT) begin
      if (we_q) merge_d = merged;
      else      rdata_d = ext;
    end
  end

  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_DONE);
    resp_err   = (state_q == ST_DONE) & err_q;
    resp_rdata = (state_q == ST_DONE) ? rdata_q : '0;
    mem_we     = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    unique case (state_q)
      ST_ISSUE: begin
        mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_we = wstore;
        mem_wd = wstore ? wdata_q : '0;
      end
      ST_WAIT: begin
        mem_a = {addr_q[ADDR_W-1:2], 2'b00};
      end
      ST_WRITE: begin
        mem_a  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_we = 1'b1;
        mem_wd = merge_q;
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized bench for dmem_lsu with a memory array model and reference model.
// Per-cycle monitor checks handshake, memory port and responses.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [7:0]  mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic [31:0] ref_mem [0:63];

  bit          pending = 0;
  int          cyc = 0;
  int          p_acc, p_due, p_we, we_cnt;
  logic [5:0]  p_idx;
  logic [31:0] p_old, p_rdata;
  logic        p_err;
  int          last_lat, last_we;
  logic [31:0] last_rdata;
  logic        last_err;

  dmem_lsu #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    mem_rd <= mem[mem_a[7:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (pending) begin
        ref_mem[p_idx] = p_old;
        pending = 0;
      end
    end else begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, !pending});
      if (!pending) chk("mem_a_idle", {24'b0, mem_a}, 32'h0);
      if (mem_we) begin
        we_cnt++;
        chk("we_when_idle", {31'b0, pending}, 32'h1);
        chk("mem_a", {24'b0, mem_a}, {24'b0, p_idx, 2'b00});
        chk("mem_wd", mem_wd, ref_mem[p_idx]);
      end
      if (pending && cyc == p_due) begin
        chk("resp_valid", {31'b0, resp_valid}, 32'h1);
        chk("resp_err", {31'b0, resp_err}, {31'b0, p_err});
        chk("resp_rdata", resp_rdata, p_rdata);
        chk("we_count", we_cnt, p_we);
        last_lat   = cyc - p_acc;
        last_we    = we_cnt;
        last_rdata = resp_rdata;
        last_err   = resp_err;
        pending    = 0;
      end else begin
        chk("resp_valid_idle", {31'b0, resp_valid}, 32'h0);
      end
      if (req_valid && req_ready) begin
        logic [31:0] w, m, v, nw;
        int          sh, nb;
        p_idx   = req_addr[7:2];
        sh      = 8 * int'(req_addr[1:0]);
        nb      = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
        m       = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
        w       = ref_mem[p_idx];
        p_old   = w;
        p_acc   = cyc;
        we_cnt  = 0;
        p_err   = (req_size == 2'd3)
               || (req_size == 2'd1 && req_addr[0])
               || (req_size == 2'd2 && req_addr[1:0] != 2'd0);
        p_rdata = 0;
        if (p_err) begin
          p_due = cyc + 1;
          p_we  = 0;
        end else if (req_we) begin
          nw = (w & ~(m << sh)) | ((req_wdata & m) << sh);
          ref_mem[p_idx] = nw;
          p_due = cyc + ((nb == 4) ? 2 : 4);
          p_we  = 1;
        end else begin
          v = (w >> sh) & m;
          if (req_signed && v[8*nb-1]) v = v | ~m;
          p_rdata = v;
          p_due = cyc + 3;
          p_we  = 0;
        end
        pending = 1;
      end
      cyc++;
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 30; i++) begin
      if (req_ready) return;
      @(posedge clk); #1;
    end
    chk("ready_timeout", 32'h0, 32'h1);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] ad,
                        input logic [31:0] wd, input bit hold);
    wait_ready();
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sg;
    req_addr   = ad;
    req_wdata  = wd;
    @(posedge clk); #1;
    req_valid  = hold;
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    for (int i = 0; i < 12; i++) begin
      if (!pending) break;
      @(posedge clk); #1;
    end
    if (pending) chk("resp_timeout", 32'h0, 32'h1);
    req_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'b0, resp_err}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_a", {24'b0, mem_a}, 32'h0);
    chk("rst_wd", mem_wd, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
    chk("sw_lat", last_lat, 2);
    chk("sw_we", last_we, 1);
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    chk("lw_lat", last_lat, 3);
    chk("lw_data", last_rdata, 32'h11223344);
    do_req(1, 2'd0, 0, 32'h11, 32'hAB, 0);
    chk("sb_lat", last_lat, 4);
    chk("sb_we", last_we, 1);
    chk("sb_mem", mem[4], 32'h1122AB44);
    do_req(1, 2'd0, 0, 32'h11, 32'h80, 0);
    do_req(0, 2'd0, 1, 32'h11, 32'h0, 0);
    chk("lb_signed", last_rdata, 32'hFFFFFF80);
    do_req(0, 2'd0, 0, 32'h11, 32'h0, 1);
    chk("lb_unsigned", last_rdata, 32'h00000080);
    do_req(1, 2'd2, 0, 32'h10, 32'h11223344, 0);
    do_req(1, 2'd1, 0, 32'h12, 32'h1234BEEF, 0);
    chk("sh_mem", mem[4], 32'hBEEF3344);
    do_req(0, 2'd1, 1, 32'h12, 32'h0, 0);
    chk("lh_signed", last_rdata, 32'hFFFFBEEF);

    do_req(0, 2'd1, 0, 32'h03, 32'h0, 0);
    chk("err_half_lat", last_lat, 1);
    chk("err_half", {31'b0, last_err}, 32'h1);
    chk("err_half_we", last_we, 0);
    do_req(1, 2'd2, 0, 32'h06, 32'hDEADBEEF, 0);
    chk("err_word", {31'b0, last_err}, 32'h1);
    chk("err_word_we", last_we, 0);
    do_req(1, 2'd3, 0, 32'h08, 32'hDEADBEEF, 0);
    chk("err_rsvd_lat", last_lat, 1);
    chk("err_rsvd", {31'b0, last_err}, 32'h1);
    chk("err_rsvd_we", last_we, 0);

    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    chk("rst_pre_we", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mid_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_mid_a", {24'b0, mem_a}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(0, 2'd2, 0, 32'h10, 32'h0, 0);
    chk("rst_lw_data", last_rdata, 32'hBEEF3344);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad[1:0] = 2'($urandom_range(0, 1) * 2);
      do_req(1'($urandom), 2'($urandom), 1'($urandom), ad, $urandom,
             1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
